kbd_text_ctrl: RTL
==================

# kbd_text_ctrl

Keyboard text-entry controller sitting between the PS/2 byte receiver and the scancode-to-ASCII ROM / character display RAM. It consumes raw scancode bytes, filters break/extended prefixes, tracks shift, looks each make code up in the synchronous scancode ROM, and writes the resulting character at a managed cursor into the display RAM. It owns the cursor, which handles newline, backspace and wrap-around with row clearing. The VGA side reads the RAM at `{row, col}`.

## Interface
- `COLS`, 70, visible columns per row (≤128)
- `ROWS`, 30, text rows (≤32)

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  8  scancode byte from PS/2 receiver
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  controller accepts a byte this cycle
- `rom_addr`  out  8  scancode ROM address
- `rom_data`  in  8  ROM ASCII; valid one cycle after `rom_addr`; 0x00 = unmapped
- `wr_en`  out  1  display RAM write strobe
- `wr_addr`  out  12  `{row[4:0], col[6:0]}`
- `wr_data`  out  8  character to write
- `cur_col`  out  7  cursor column
- `cur_row`  out  5  cursor row

## Operation
- A byte is accepted on a rising edge with `in_valid && in_ready`. `in_ready` is high only in IDLE.
- FSM states:
  - **IDLE**: on accept, decode the byte.
  - 0xF0 sets `brk`; 0xE0 sets `ext`; both stay in IDLE.
  - Any other byte with `brk` or `ext` set:
    - if it is shift (0x12/0x59) and `brk`=1, clear `shift`;
    - clear both flags, drop the byte, stay in IDLE.
  - Shift make sets `shift` and stays in IDLE.
  - Else latch the code and go to LOOKUP.
  - **LOOKUP**: `rom_addr` = code → WRITE.
  - **WRITE**, decision on code / `rom_data`:
    - 0x5A (enter): `col`←0, `row`←row+1.
    - 0x66 (backspace): no-op at (0,0). Else step back one cell (col 0 → col `COLS`-1 of row-1) and write 0x00 there.
    - `rom_data`=0: nothing.
    - Printable: write `rom_data` at the cursor. If `shift` and the char is 'a'..'z', write char−0x20. Then `col`+1; at `COLS`-1 go to col 0, row+1.
  - Row advance from `ROWS`-1 wraps to 0. Any row advance goes to CLEAR; otherwise return to IDLE.
  - **CLEAR**: write 0x00 to cols 0..`COLS`-1 of the new row, one per cycle → IDLE.
- `wr_addr` high bits above `ROWS`/`COLS` are never produced. Column arithmetic is 7-bit with explicit compare, never modulo.

## Timing
- Printable or backspace byte accepted at edge 0: LOOKUP in cycle 1, `wr_en` in cycle 2, cursor updated at edge 3, `in_ready` high in cycle 3.
- Prefix and shift bytes: 1 per cycle.
- A row advance adds `COLS` CLEAR cycles. `in_ready` stays low throughout.
- `wr_en` is high for exactly one cycle per written cell.
- Reset values: `in_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rom_addr`=0, `cur_col`=0, `cur_row`=0.
- Internal reset values: state IDLE, `brk`/`ext`/`shift` clear.
- Reset mid-operation aborts any write or CLEAR immediately. RAM contents are untouched.

## Configuration
- `KBD_TEXT_TYPEMATIC_EN` defined: a make code equal to the last accepted make code, with no intervening break, is dropped in IDLE. This suppresses auto-repeat. A break of that code clears the "last make" register.
- Undefined: every make code is processed, so a held key repeats.

## Structure
- `kbd_pkg` holds:
  - scancode constants: `SC_BREAK` 0xF0, `SC_EXT` 0xE0, `SC_LSHIFT` 0x12, `SC_RSHIFT` 0x59, `SC_ENTER` 0x5A, `SC_BKSP` 0x66;
  - the FSM state enum (IDLE, LOOKUP, WRITE, CLEAR);
  - the address-width constants.
- Sub-module `kbd_cursor` holds the col/row registers with `advance`, `newline` and `back` commands. It outputs wrap / row-change flags.

## Test plan
- Reset, then send 0x1C ('a', ROM 0x61): `wr_en` once, at cycle 2, with `wr_addr`=0x000, `wr_data`=0x61; afterwards `cur_col`=1.
- Send 0x12, 0x1C, 0xF0, 0x12, 0x1C. Expect writes 0x41 @0x000 and 0x61 @0x001.
- Send 0x1C, 0xF0, 0x1C. Expect exactly one write; `cur_col`=1.
- Fill row 0 with 70 chars. Expect the cursor to wrap to (0,1), then 70 CLEAR writes of 0x00 to 0x080..0x0C5, with `in_ready` low throughout.
- Send backspace at (0,1): expect a write of 0x00 @0x045 and cursor (69,0). Backspace at (0,0): no write.
- With `KBD_TEXT_TYPEMATIC_EN`, send 0x1C ×3 without break: expect one write. Without the macro: three writes.

Source files
------------

// File: rtl/kbd_text_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | kbd_pkg : scancode constants, FSM states and address widths shared by the   |
// |           keyboard text-entry controller.               Rev 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

package kbd_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam int COL_W  = 7;
  localparam int ROW_W  = 5;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WRITE  = 2'd2,
    ST_CLEAR  = 2'd3
  } state_t;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

  function automatic logic [7:0] apply_shift(input logic [7:0] ch, input logic shift);
    if (shift && (ch >= 8'h61) && (ch <= 8'h7A)) return ch - 8'h20;
    return ch;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kbd_text_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | kbd_text_ctrl_if : byte input, scancode ROM, display RAM and cursor bus.   |
// |                                                        Rev 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface kbd_text_ctrl_if;
  import kbd_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        rom_addr;
  logic [7:0]        rom_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;

  modport master (
    input  in_data, in_valid, rom_data,
    output in_ready, rom_addr, wr_en, wr_addr, wr_data, cur_col, cur_row
  );

  modport slave (
    output in_data, in_valid, rom_data,
    input  in_ready, rom_addr, wr_en, wr_addr, wr_data, cur_col, cur_row
  );
endinterface

`default_nettype wire

// File: rtl/kbd_text_ctrl_cursor.sv
// +----------------------------------------------------------------------------+
// | kbd_cursor : text cursor with advance / newline / back commands.           |
// |                                                        Rev 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module kbd_cursor
  import kbd_pkg::*;
#(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_advance,
  input  wire logic             i_newline,
  input  wire logic             i_back,
  output logic [COL_W-1:0]      o_col,
  output logic [ROW_W-1:0]      o_row,
  output logic [COL_W-1:0]      o_prev_col,
  output logic [ROW_W-1:0]      o_prev_row,
  output logic                  o_at_home,
  output logic                  o_row_adv
);

  localparam logic [COL_W-1:0] c_last_col = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] c_last_row = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_next_row;

  assign w_next_row = (r_row == c_last_row) ? '0 : r_row + 1'b1;
  assign o_at_home  = (r_col == '0) && (r_row == '0);
  assign o_row_adv  = i_newline || (i_advance && (r_col == c_last_col));

  // Cell just behind the cursor; only meaningful when not at home.
  assign o_prev_col = (r_col == '0) ? c_last_col : r_col - 1'b1;
  assign o_prev_row = (r_col == '0) ? r_row - 1'b1 : r_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_back) begin
      if (!o_at_home) begin
        r_col <= o_prev_col;
        r_row <= o_prev_row;
      end
    end else if (i_newline) begin
      r_col <= '0;
      r_row <= w_next_row;
    end else if (i_advance) begin
      if (r_col == c_last_col) begin
        r_col <= '0;
        r_row <= w_next_row;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

endmodule

`default_nettype wire

// File: rtl/kbd_text_ctrl.sv
// +----------------------------------------------------------------------------+
// | kbd_text_ctrl : scancode stream to display-RAM text entry controller.      |
// | Optional KBD_TEXT_TYPEMATIC_EN drops auto-repeated make codes. Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module kbd_text_ctrl
  import kbd_pkg::*;
#(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  wire logic       clk,
  input  wire logic       rst,
  kbd_text_ctrl_if.master bus
);

  localparam logic [COL_W-1:0] c_last_col = COL_W'(COLS - 1);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_brk;
  logic             r_ext;
  logic             r_shift;
  logic [7:0]       r_code;
  logic [COL_W-1:0] r_clr_col;
`ifdef KBD_TEXT_TYPEMATIC_EN
  logic [7:0]       r_last;
`endif

  logic              w_accept;
  logic              w_in_write;
  logic              w_advance;
  logic              w_newline;
  logic              w_back;
  logic              w_print;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [COL_W-1:0]  w_prev_col;
  logic [ROW_W-1:0]  w_prev_row;
  logic              w_at_home;
  logic              w_row_adv;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        w_wr_data;

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_in_write = (r_state == ST_WRITE);
  assign w_print    = (r_code != SC_ENTER) && (r_code != SC_BKSP) && (bus.rom_data != 8'h00);
  assign w_advance  = w_in_write && w_print;
  assign w_newline  = w_in_write && (r_code == SC_ENTER);
  assign w_back     = w_in_write && (r_code == SC_BKSP) && !w_at_home;

  kbd_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .i_advance  (w_advance),
    .i_newline  (w_newline),
    .i_back     (w_back),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_prev_col (w_prev_col),
    .o_prev_row (w_prev_row),
    .o_at_home  (w_at_home),
    .o_row_adv  (w_row_adv)
  );

  // ROM data only arrives in WRITE, so the RAM port is decoded from state.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = 8'h00;
    if (w_advance) begin
      w_wr_en   = 1'b1;
      w_wr_addr = {w_row, w_col};
      w_wr_data = apply_shift(bus.rom_data, r_shift);
    end else if (w_back) begin
      w_wr_en   = 1'b1;
      w_wr_addr = {w_prev_row, w_prev_col};
    end else if (r_state == ST_CLEAR) begin
      w_wr_en   = 1'b1;
      w_wr_addr = {w_row, r_clr_col};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_brk      <= 1'b0;
      r_ext      <= 1'b0;
      r_shift    <= 1'b0;
      r_code     <= 8'h00;
      r_clr_col  <= '0;
`ifdef KBD_TEXT_TYPEMATIC_EN
      r_last     <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (bus.in_data == SC_BREAK) begin
              r_brk <= 1'b1;
            end else if (bus.in_data == SC_EXT) begin
              r_ext <= 1'b1;
            end else if (r_brk || r_ext) begin
              if (r_brk && is_shift(bus.in_data)) r_shift <= 1'b0;
`ifdef KBD_TEXT_TYPEMATIC_EN
              if (r_brk && (bus.in_data == r_last)) r_last <= 8'h00;
`endif
              r_brk <= 1'b0;
              r_ext <= 1'b0;
            end else if (is_shift(bus.in_data)) begin
              r_shift <= 1'b1;
`ifdef KBD_TEXT_TYPEMATIC_EN
            end else if (bus.in_data == r_last) begin
              r_state <= ST_IDLE;
`endif
            end else begin
              r_code     <= bus.in_data;
              r_state    <= ST_LOOKUP;
              r_in_ready <= 1'b0;
`ifdef KBD_TEXT_TYPEMATIC_EN
              r_last     <= bus.in_data;
`endif
            end
          end
        end
        ST_LOOKUP: r_state <= ST_WRITE;
        ST_WRITE: begin
          if (w_row_adv) begin
            r_clr_col <= '0;
            r_state   <= ST_CLEAR;
          end else begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_clr_col == c_last_col) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_clr_col <= r_clr_col + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.rom_addr = r_code;
  assign bus.wr_en    = w_wr_en;
  assign bus.wr_addr  = w_wr_addr;
  assign bus.wr_data  = w_wr_data;
  assign bus.cur_col  = w_col;
  assign bus.cur_row  = w_row;

endmodule

`default_nettype wire
